// File: rtl/mux_nx1_stream_pkg.sv
// Shared definitions for the N-to-1 streaming multiplexer.
//   MODE_MANUAL / MODE_RR : encodings of the mode input
//   sel_width()           : channel-index width for a given channel count (min 1)
package mux_nx1_stream_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Smallest w >= 1 with 2**w >= n.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_nx1_stream_if.sv
// Handshake/bus bundle of mux_nx1_stream.
//   Producer side : in_data, in_valid, in_ready, mode, sel
//   Consumer side : out_data, out_valid, out_ready, out_chan
// Modport slave is the multiplexer itself; master is whoever drives it.
interface mux_nx1_stream_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//   req         : per-channel request
//   advance     : the current grant was consumed; move pointer past it
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : index of the granted channel
//   grant_valid : some channel is granted
module mux_nx1_stream_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // First requester at or after the pointer, wrapping modulo CHANNELS.
    always_comb begin
        int               cand;
        logic [SEL_W-1:0] cand_idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end else begin
                cand = cand;
            end
            cand_idx = SEL_W'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

    // Pointer moves one past the consumed grant; explicit wrap keeps
    // non-power-of-two channel counts inside range.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            if (int'(grant_idx) == CHANNELS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SEL_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// Parametrised N-to-1 registered stream multiplexer.
//   clk : sole clock
//   rst : synchronous active-high reset
//   bus : mux_nx1_stream_if.slave -- per-lane valid/ready inputs, mode/sel,
//         and one registered valid/ready output carrying data and source index.
// mode=0 follows sel; mode=1 grants round-robin among valid lanes. A word is
// accepted whenever the output register is empty or being drained this cycle.
module mux_nx1_stream
    import mux_nx1_stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst,
    mux_nx1_stream_if.slave    bus
);

    logic [CHANNELS-1:0] rr_grant_s;
    logic [SEL_W-1:0]    rr_idx_s;
    logic                rr_valid_s;
    logic                load_en_s;
    logic [CHANNELS-1:0] ready_s;
    logic [SEL_W-1:0]    chan_s;
    logic                xfer_s;
    logic                rr_advance_s;
    logic [WIDTH-1:0]    lane_s;

    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
    logic                out_valid_q, out_valid_d;

    mux_nx1_stream_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.in_valid),
        .advance     (rr_advance_s),
        .grant       (rr_grant_s),
        .grant_idx   (rr_idx_s),
        .grant_valid (rr_valid_s)
    );

    // Mode mux: choose which lane is offered load_en and which index it carries.
    always_comb begin
        load_en_s = !out_valid_q || bus.out_ready;
        ready_s   = '0;
        chan_s    = '0;
        if (rst) begin
            ready_s = '0;
        end else begin
            case (bus.mode)
                MODE_MANUAL: begin
                    chan_s = bus.sel;
                    // Out-of-range select leaves every lane un-ready.
                    if (int'(bus.sel) < CHANNELS) begin
                        ready_s[bus.sel] = load_en_s;
                    end else begin
                        ready_s = '0;
                    end
                end
                MODE_RR: begin
                    chan_s  = rr_idx_s;
                    ready_s = rr_grant_s & {CHANNELS{load_en_s && rr_valid_s}};
                end
                default: begin
                    ready_s = '0;
                end
            endcase
        end
        xfer_s       = |(bus.in_valid & ready_s);
        rr_advance_s = xfer_s && (bus.mode == MODE_RR);
    end

    // Lane extraction by compare rather than a variable slice so an index
    // past CHANNELS-1 can never select out of range.
    always_comb begin
        lane_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == chan_s) begin
                lane_s = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                lane_s = lane_s;
            end
        end
    end

    // Output register next state: load wins over drain, so a same-edge
    // drain+load keeps out_valid high with the new word.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (xfer_s) begin
            out_data_d  = lane_s;
            out_chan_d  = chan_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream (WIDTH=8, CHANNELS=4). Stimulus pushes
// the expected word/channel when it expects an input transfer; a monitor pops
// and compares on each output transfer.
module tb_mux_nx1_stream;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    mux_nx1_stream_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus_if ();

    mux_nx1_stream #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("FAIL unexpected_out: got data %0h chan %0d, expected none",
                         bus_if.out_data, bus_if.out_chan);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", {24'h0, bus_if.out_data}, {24'h0, e.d});
                check("out_chan", {30'h0, bus_if.out_chan}, {30'h0, e.c});
            end
        end
    end

    task automatic drive(input logic md, input logic [1:0] s, input logic [3:0] v,
                         input logic [31:0] lanes, input logic ordy);
        bus_if.mode      = md;
        bus_if.sel       = s;
        bus_if.in_valid  = v;
        bus_if.in_data   = lanes;
        bus_if.out_ready = ordy;
    endtask

    // One cycle: check in_ready mid-cycle, record expectation, advance to edge+1.
    task automatic cyc(input string nm, input logic [3:0] exp_rdy, input bit push,
                       input logic [7:0] d, input logic [1:0] c);
        exp_t e;
        #2;
        check(nm, {28'h0, bus_if.in_ready}, {28'h0, exp_rdy});
        if (push) begin
            e.d = d;
            e.c = c;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_rdy [6];
        n_cmp  = 0;
        n_fail = 0;
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset with every lane valid
        rst = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1);
        cyc("rst_rdy0", 4'b0000, 0, 8'h00, 2'd0);
        cyc("rst_rdy1", 4'b0000, 0, 8'h00, 2'd0);
        check("rst_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
        check("rst_out_data",  {24'h0, bus_if.out_data}, 32'h0);
        check("rst_out_chan",  {30'h0, bus_if.out_chan}, 32'h0);
        rst = 1'b0;

        // Round-robin fairness: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            cyc("rr_rdy", rr_rdy[i], 1, 8'h10 + 8'(i % 4), 2'(i % 4));
        end

        // Manual pass-through on sel=2
        drive(1'b0, 2'd2, 4'b0100, 32'h13A51110, 1'b1);
        cyc("man_rdy", 4'b0100, 1, 8'hA5, 2'd2);
        check("man_out_data",  {24'h0, bus_if.out_data}, 32'hA5);
        check("man_out_chan",  {30'h0, bus_if.out_chan}, 32'h2);
        check("man_out_valid", {31'h0, bus_if.out_valid}, 32'h1);
        drive(1'b0, 2'd2, 4'b0000, 32'h13A51110, 1'b1);
        cyc("man_rdy_novalid", 4'b0100, 0, 8'h00, 2'd0);

        // Sparse RR with wrap (pointer is 2 here)
        drive(1'b1, 2'd0, 4'b0100, 32'h23222120, 1'b1);
        cyc("sp_rdy_ch2", 4'b0100, 1, 8'h22, 2'd2);
        drive(1'b1, 2'd0, 4'b0010, 32'h23222120, 1'b1);
        cyc("sp_rdy_ch1", 4'b0010, 1, 8'h21, 2'd1);
        drive(1'b1, 2'd0, 4'b0101, 32'h23222120, 1'b1);
        cyc("sp_rdy_ch2b", 4'b0100, 1, 8'h22, 2'd2);
        drive(1'b1, 2'd0, 4'b0001, 32'h23222120, 1'b1);
        cyc("sp_rdy_wrap0", 4'b0001, 1, 8'h20, 2'd0);
        drive(1'b1, 2'd0, 4'b0000, 32'h23222120, 1'b1);
        cyc("rr_none", 4'b0000, 0, 8'h00, 2'd0);

        // Back-pressure: hold 3C for three cycles
        drive(1'b0, 2'd0, 4'b0001, 32'h0000003C, 1'b1);
        cyc("bp_load", 4'b0001, 1, 8'h3C, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 4'b1111, 32'h11223344 + 32'(i * 32'h01010101), 1'b0);
            check("bp_data",  {24'h0, bus_if.out_data}, 32'h3C);
            check("bp_valid", {31'h0, bus_if.out_valid}, 32'h1);
            cyc("bp_rdy", 4'b0000, 0, 8'h00, 2'd0);
        end
        check("bp_chan", {30'h0, bus_if.out_chan}, 32'h0);
        drive(1'b1, 2'd0, 4'b0010, 32'h00005A00, 1'b1);
        cyc("bp_replace_rdy", 4'b0010, 1, 8'h5A, 2'd1);
        check("bp_replace_valid", {31'h0, bus_if.out_valid}, 32'h1);
        check("bp_replace_data",  {24'h0, bus_if.out_data}, 32'h5A);

        // Reset while a word (77) is stalled
        drive(1'b0, 2'd3, 4'b1000, 32'h77000044, 1'b1);
        cyc("rs_load", 4'b1000, 1, 8'h77, 2'd3);
        drive(1'b0, 2'd3, 4'b0000, 32'h77000044, 1'b0);
        cyc("rs_stall", 4'b0000, 0, 8'h00, 2'd0);
        check("rs_held", {24'h0, bus_if.out_data}, 32'h77);
        rst = 1'b1;
        exp_q.delete();
        cyc("rs_rst_rdy", 4'b0000, 0, 8'h00, 2'd0);
        rst = 1'b0;
        check("rs_valid_clr", {31'h0, bus_if.out_valid}, 32'h0);
        drive(1'b1, 2'd0, 4'b1111, 32'h77000044, 1'b1);
        cyc("rs_ptr0", 4'b0001, 1, 8'h44, 2'd0);
        drive(1'b1, 2'd0, 4'b0000, 32'h77000044, 1'b1);
        cyc("drain0", 4'b0000, 0, 8'h00, 2'd0);
        cyc("drain1", 4'b0000, 0, 8'h00, 2'd0);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
